// File: rtl/rr_grant_scheduler_pkg.sv
// rtl/rr_grant_scheduler_pkg.sv - shared types and helpers for the round-robin grant scheduler
package rr_grant_scheduler_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Widest one-hot vector the rotate helper handles; callers truncate to their own N.
    localparam int MAX_N = 64;

    // Ceiling log2, never less than 1 so that derived vectors always have a bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                r[(i + 1 == n) ? 0 : i + 1] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational cyclic first-set search starting at a one-hot pointer
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [N-1:0]   ptr_i,
    output logic [N-1:0]   win_o,
    output logic [IDW-1:0] win_id_o
);

    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] dbl_iso;

    // Lower half holds requests at or above ptr; the upper half is the unmasked wrap-around fallback.
    assign dbl_req = {req_i, req_i & ~(ptr_i - N'(1))};
    assign dbl_iso = dbl_req & (~dbl_req + (2*N)'(1));
    assign win_o   = dbl_iso[N-1:0] | dbl_iso[2*N-1:N];

    always_comb begin
        win_id_o = '0;
        for (int i = 0; i < N; i++) begin
            if (win_o[i]) begin
                win_id_o = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// rtl/rr_grant_scheduler.sv - round-robin scheduler with registered one-hot grant and hold timeout
module rr_grant_scheduler
    import rr_grant_scheduler_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int HOLD_MAX = 8,
    localparam int IDW      = clog2_min1(N),
    localparam int HCW      = clog2_min1(HOLD_MAX + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic [N-1:0]   ptr,
    output logic           timeout
);

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           timeout_q, timeout_d;

    logic [N-1:0]   win;
    logic [IDW-1:0] win_id;
    logic           owner_req;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .win_o    (win),
        .win_id_o (win_id)
    );

    assign owner_req = |(req & gnt_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= N'(1);
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d    = ST_GRANT;
                    gnt_d      = win;
                    gnt_id_d   = win_id;
                    ptr_d      = N'(rotl1(MAX_N'(win), N));
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                // An explicit release wins over the timeout, so no pulse is raised in that case.
                if (done || !owner_req) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end else if (HOLD_MAX != 0 && int'(hold_cnt_q) == HOLD_MAX - 1) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    timeout_d = 1'b1;
                end else if (int'(hold_cnt_q) < HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;
    assign ptr       = ptr_q;
    assign timeout   = timeout_q;

endmodule
